// File: rtl/uart_rx_if.sv
// Serial line and received-word outputs of uart_rx, plus a debug view of the receiver FSM state.
`timescale 1ns/1ps
interface uart_rx_if #(
  parameter int DATA_W = 8
);
  logic              i_rx;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_parity_err;
  logic              o_frame_err;
  logic              o_busy;
  logic [2:0]        dbg_state;

  // Strobe protocol, no ready: o_valid is a one-cycle pulse that cannot be stalled; o_data holds
  // until the next good frame, o_parity_err only qualifies o_valid, o_frame_err pulses on its own.
  modport master (
    output i_rx,
    input  o_data, o_valid, o_parity_err, o_frame_err, o_busy, dbg_state
  );
  modport slave (
    input  i_rx,
    output o_data, o_valid, o_parity_err, o_frame_err, o_busy, dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start-bit validation, mid-bit sampling, optional parity,
// one-cycle valid strobe with parity/frame error flags.
`timescale 1ns/1ps
module uart_rx #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 27,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  uart_rx_if.slave rx_if
);

  localparam int PW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              rx_meta, rx_s, rx_prev;
  logic [PW-1:0]     presc;
  logic [3:0]        tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_mis;
  logic [DATA_W-1:0] data_q;
  logic              valid_q, perr_q, ferr_q;

  logic tick, fall, mid_start, mid_bit;

  assign tick      = (presc == PRESC_MAX);
  assign fall      = rx_prev & ~rx_s;
  assign mid_start = tick && (tick_cnt == 4'd7);
  assign mid_bit   = tick && (tick_cnt == 4'd15);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fall) state_d = START;
      START:   if (mid_start) state_d = rx_s ? IDLE : DATA;
      DATA:    if (mid_bit && (bit_cnt == BITS_LAST)) state_d = PARITY_EN ? PARITY : STOP;
      PARITY:  if (mid_bit) state_d = STOP;
      STOP:    if (mid_bit) state_d = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      presc    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_mis  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_meta <= rx_if.i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;

      // Restarting the oversample phase on the edge puts every sample a fixed tick count from it.
      if (state_q == IDLE && fall) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (state_q == START && mid_start) tick_cnt <= '0;
        else if (tick)                     tick_cnt <= tick_cnt + 4'd1;
      end

      case (state_q)
        IDLE: if (fall) par_mis <= 1'b0;
        START: if (mid_start) bit_cnt <= '0;
        DATA: if (mid_bit) begin
          shreg   <= {rx_s, shreg[DATA_W-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: if (mid_bit) par_mis <= rx_s ^ (^shreg) ^ PARITY_ODD;
        STOP: if (mid_bit) begin
          if (rx_s) begin
            data_q  <= shreg;
            valid_q <= 1'b1;
            perr_q  <= par_mis;
          end else begin
            ferr_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_if.o_data       = data_q;
  assign rx_if.o_valid      = valid_q;
  assign rx_if.o_parity_err = perr_q;
  assign rx_if.o_frame_err  = ferr_q;
  assign rx_if.o_busy       = (state_q != IDLE);
  assign rx_if.dbg_state    = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one receiver without parity (BAUD_DIV=1), one with even parity (BAUD_DIV=2).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DW     = 8;
  localparam int BD_A   = 1;
  localparam int BD_P   = 2;
  localparam int CLK_NS = 10;
  localparam int BIT_A  = 16 * BD_A * CLK_NS;
  localparam int BIT_P  = 16 * BD_P * CLK_NS;
  localparam bit ODD_P  = 1'b0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  always #(CLK_NS/2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if #(.DATA_W(DW)) if_a ();
  uart_rx_if #(.DATA_W(DW)) if_p ();

  uart_rx #(.DATA_W(DW), .BAUD_DIV(BD_A), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .rx_if(if_a)
  );
  uart_rx #(.DATA_W(DW), .BAUD_DIV(BD_P), .PARITY_EN(1'b1), .PARITY_ODD(ODD_P)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .rx_if(if_p)
  );

  // ---------------- monitors (sole writers of the capture arrays) ----------------
  logic [DW-1:0] got_a_d[64];
  int unsigned   got_a_cyc[64];
  int            got_a_n = 0;
  int            ferr_a = 0, perr_a = 0;
  logic [DW-1:0] got_p_d[64];
  logic          got_p_e[64];
  int            got_p_n = 0;
  int            ferr_p = 0, perr_p = 0;

  always @(negedge clk) begin
    if (if_a.o_valid && got_a_n < 64) begin
      got_a_d[got_a_n]   <= if_a.o_data;
      got_a_cyc[got_a_n] <= cyc;
      got_a_n            <= got_a_n + 1;
    end
    if (if_a.o_frame_err)  ferr_a <= ferr_a + 1;
    if (if_a.o_parity_err) perr_a <= perr_a + 1;
    if (if_p.o_valid && got_p_n < 64) begin
      got_p_d[got_p_n] <= if_p.o_data;
      got_p_e[got_p_n] <= if_p.o_parity_err;
      got_p_n          <= got_p_n + 1;
    end
    if (if_p.o_frame_err)  ferr_p <= ferr_p + 1;
    if (if_p.o_parity_err) perr_p <= perr_p + 1;
  end

  // ---------------- scoreboard state / reference model ----------------
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_p[$];
  logic          exp_pe[$];
  logic [DW-1:0] last_a = '0;
  int rd_a = 0, rd_p = 0;
  int n_checks = 0, n_pass = 0;

  // A parity error means the total count of ones over data plus parity bit has the wrong oddness.
  function automatic logic model_perr(input logic [DW-1:0] d, input logic pbit, input logic odd);
    int ones;
    ones = $countones(d) + int'(pbit);
    return ((ones % 2) == 1) != odd;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_line(input int sel, input logic v);
    if (sel == 0) if_a.i_rx = v;
    else          if_p.i_rx = v;
  endtask

  task automatic send_frame(input int sel, input logic [DW-1:0] d, input logic has_par,
                            input logic pbit, input logic stop, input int bit_ns);
    set_line(sel, 1'b0);
    #(bit_ns);
    for (int i = 0; i < DW; i++) begin
      set_line(sel, d[i]);
      #(bit_ns);
    end
    if (has_par) begin
      set_line(sel, pbit);
      #(bit_ns);
    end
    set_line(sel, stop);
    #(bit_ns);
  endtask

  task automatic align;
    @(negedge clk);
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #23;
    n_checks++; if (if_a.o_data !== 8'h00) $display("FAIL reset_data_a: got %h exp 00", if_a.o_data); else n_pass++;
    n_checks++; if ({if_a.o_valid, if_a.o_parity_err, if_a.o_frame_err, if_a.o_busy} !== 4'b0)
      $display("FAIL reset_flags_a: got %b exp 0000", {if_a.o_valid, if_a.o_parity_err, if_a.o_frame_err, if_a.o_busy});
    else n_pass++;
    n_checks++; if ({if_p.o_data, if_p.o_valid, if_p.o_parity_err, if_p.o_frame_err, if_p.o_busy} !== 12'h0)
      $display("FAIL reset_outs_p: got %h exp 000", {if_p.o_data, if_p.o_valid, if_p.o_parity_err, if_p.o_frame_err, if_p.o_busy});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if ({if_a.o_busy, if_p.o_busy} !== 2'b00) $display("FAIL idle_busy: got %b exp 00", {if_a.o_busy, if_p.o_busy}); else n_pass++;
    n_checks++; if ({if_a.dbg_state, if_p.dbg_state} !== 6'd0) $display("FAIL idle_state: got %h exp 0", {if_a.dbg_state, if_p.dbg_state}); else n_pass++;
  endtask

  task automatic test_basic;
    int unsigned start_cyc, lat, lat_exp;
    int ferr0, perr0;
    ferr0 = ferr_a; perr0 = perr_a;
    align();
    start_cyc = cyc;
    exp_a.push_back(8'hA5); last_a = 8'hA5;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, BIT_A);
    repeat (20) @(negedge clk);
    // 2-flop sync + edge register, then stop sample at 8+16*(DW+1) ticks.
    lat_exp = 3 + (8 + 16 * (DW + 1)) * BD_A;
    n_checks++; if (got_a_n - rd_a !== exp_a.size()) $display("FAIL basic_count: got %0d exp %0d", got_a_n - rd_a, exp_a.size()); else n_pass++;
    if (rd_a < got_a_n) begin
      lat = got_a_cyc[rd_a] - start_cyc;
      n_checks++; if (lat + 1 < lat_exp || lat > lat_exp + 1) $display("FAIL basic_latency: got %0d exp %0d", lat, lat_exp); else n_pass++;
      n_checks++; if (got_a_d[rd_a] !== exp_a[0]) $display("FAIL basic_data: got %h exp %h", got_a_d[rd_a], exp_a[0]); else n_pass++;
      rd_a++;
    end
    exp_a.delete();
    n_checks++; if (ferr_a - ferr0 !== 0 || perr_a - perr0 !== 0) $display("FAIL basic_errflags: got ferr %0d perr %0d exp 0 0", ferr_a - ferr0, perr_a - perr0); else n_pass++;
    n_checks++; if (if_a.o_busy !== 1'b0) $display("FAIL basic_busy_after: got %b exp 0", if_a.o_busy); else n_pass++;
  endtask

  task automatic test_glitch;
    int n0, ferr0;
    n0 = got_a_n; ferr0 = ferr_a;
    align();
    set_line(0, 1'b0);
    #(4 * BD_A * CLK_NS);
    set_line(0, 1'b1);
    n_checks++; if (if_a.o_busy !== 1'b1) $display("FAIL glitch_busy_during: got %b exp 1", if_a.o_busy); else n_pass++;
    repeat (8) @(negedge clk);
    n_checks++; if (if_a.o_busy !== 1'b0) $display("FAIL glitch_busy_after: got %b exp 0", if_a.o_busy); else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++; if (got_a_n - n0 !== 0 || ferr_a - ferr0 !== 0) $display("FAIL glitch_no_output: got valid %0d ferr %0d exp 0 0", got_a_n - n0, ferr_a - ferr0); else n_pass++;
  endtask

  task automatic test_frame_err;
    int n0, ferr0;
    n0 = got_a_n; ferr0 = ferr_a;
    align();
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, BIT_A);
    #(40 * BD_A * CLK_NS);
    @(negedge clk);
    n_checks++; if (ferr_a - ferr0 !== 1) $display("FAIL ferr_pulse: got %0d cycles exp 1", ferr_a - ferr0); else n_pass++;
    n_checks++; if (got_a_n - n0 !== 0) $display("FAIL ferr_no_valid: got %0d exp 0", got_a_n - n0); else n_pass++;
    n_checks++; if (if_a.o_data !== last_a) $display("FAIL ferr_data_held: got %h exp %h", if_a.o_data, last_a); else n_pass++;
    n_checks++; if (if_a.o_busy !== 1'b1) $display("FAIL ferr_busy_in_break: got %b exp 1", if_a.o_busy); else n_pass++;
    set_line(0, 1'b1);
    repeat (2 * 16 * BD_A) @(negedge clk);
    n_checks++; if (if_a.o_busy !== 1'b0) $display("FAIL ferr_busy_release: got %b exp 0", if_a.o_busy); else n_pass++;
    align();
    exp_a.push_back(8'h81); last_a = 8'h81;
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, BIT_A);
    repeat (20) @(negedge clk);
    n_checks++; if (got_a_n - rd_a !== exp_a.size()) $display("FAIL ferr_next_count: got %0d exp %0d", got_a_n - rd_a, exp_a.size()); else n_pass++;
    while (exp_a.size() > 0) begin
      logic [DW-1:0] e;
      e = exp_a.pop_front();
      if (rd_a < got_a_n) begin
        n_checks++; if (got_a_d[rd_a] !== e) $display("FAIL ferr_next_data: got %h exp %h", got_a_d[rd_a], e); else n_pass++;
        rd_a++;
      end
    end
    n_checks++; if (ferr_a - ferr0 !== 1) $display("FAIL ferr_only_first: got %0d exp 1", ferr_a - ferr0); else n_pass++;
  endtask

  task automatic test_parity;
    logic [DW-1:0] d;
    logic pb;
    int perr0, ferr0, n_err_exp;
    perr0 = perr_p; ferr0 = ferr_p; n_err_exp = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      begin d = 8'h07; pb = 1'b1; end
      else if (i == 1) begin d = 8'h07; pb = 1'b0; end
      else begin
        d  = DW'($urandom_range(0, 255));
        pb = 1'($urandom_range(0, 1));
      end
      exp_p.push_back(d);
      exp_pe.push_back(model_perr(d, pb, ODD_P));
      if (model_perr(d, pb, ODD_P)) n_err_exp++;
      align();
      send_frame(1, d, 1'b1, pb, 1'b1, BIT_P);
      #($urandom_range(0, 2) * BIT_P);
    end
    repeat (40) @(negedge clk);
    n_checks++; if (got_p_n - rd_p !== exp_p.size()) $display("FAIL par_count: got %0d exp %0d", got_p_n - rd_p, exp_p.size()); else n_pass++;
    while (exp_p.size() > 0) begin
      logic [DW-1:0] e;
      logic ee;
      e = exp_p.pop_front();
      ee = exp_pe.pop_front();
      if (rd_p < got_p_n) begin
        n_checks++; if (got_p_d[rd_p] !== e) $display("FAIL par_data[%0d]: got %h exp %h", rd_p, got_p_d[rd_p], e); else n_pass++;
        n_checks++; if (got_p_e[rd_p] !== ee) $display("FAIL par_err[%0d]: got %b exp %b data %h", rd_p, got_p_e[rd_p], ee, e); else n_pass++;
        rd_p++;
      end
    end
    n_checks++; if (perr_p - perr0 !== n_err_exp) $display("FAIL par_err_pulses: got %0d exp %0d", perr_p - perr0, n_err_exp); else n_pass++;
    n_checks++; if (ferr_p - ferr0 !== 0) $display("FAIL par_no_ferr: got %0d exp 0", ferr_p - ferr0); else n_pass++;
  endtask

  task automatic test_random_a;
    logic [DW-1:0] d;
    for (int i = 0; i < 6; i++) begin
      d = DW'($urandom_range(0, 255));
      exp_a.push_back(d); last_a = d;
      align();
      send_frame(0, d, 1'b0, 1'b0, 1'b1, BIT_A);
      #($urandom_range(0, 2) * BIT_A);
    end
    repeat (30) @(negedge clk);
    n_checks++; if (got_a_n - rd_a !== exp_a.size()) $display("FAIL rand_count: got %0d exp %0d", got_a_n - rd_a, exp_a.size()); else n_pass++;
    while (exp_a.size() > 0) begin
      logic [DW-1:0] e;
      e = exp_a.pop_front();
      if (rd_a < got_a_n) begin
        n_checks++; if (got_a_d[rd_a] !== e) $display("FAIL rand_data[%0d]: got %h exp %h", rd_a, got_a_d[rd_a], e); else n_pass++;
        rd_a++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] words[3];
    int bit_fast;
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h55;
    // Transmitter running about 2% fast: shorter bit cell, no idle between frames.
    bit_fast = (BIT_A * 100) / 102;
    align();
    for (int i = 0; i < 3; i++) begin
      exp_a.push_back(words[i]); last_a = words[i];
      send_frame(0, words[i], 1'b0, 1'b0, 1'b1, bit_fast);
    end
    repeat (30) @(negedge clk);
    n_checks++; if (got_a_n - rd_a !== exp_a.size()) $display("FAIL b2b_count: got %0d exp %0d", got_a_n - rd_a, exp_a.size()); else n_pass++;
    while (exp_a.size() > 0) begin
      logic [DW-1:0] e;
      e = exp_a.pop_front();
      if (rd_a < got_a_n) begin
        n_checks++; if (got_a_d[rd_a] !== e) $display("FAIL b2b_data[%0d]: got %h exp %h", rd_a, got_a_d[rd_a], e); else n_pass++;
        rd_a++;
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] d;
    d = 8'h12;
    align();
    set_line(0, 1'b0);
    #(BIT_A);
    for (int i = 0; i < 3; i++) begin
      set_line(0, d[i]);
      #(BIT_A);
    end
    set_line(0, d[3]);
    #(BIT_A / 2);
    rst_n = 1'b0;
    set_line(0, 1'b1);
    #1;
    n_checks++; if ({if_a.o_data, if_a.o_valid, if_a.o_parity_err, if_a.o_frame_err, if_a.o_busy} !== 12'h0)
      $display("FAIL midrst_outs: got %h exp 000", {if_a.o_data, if_a.o_valid, if_a.o_parity_err, if_a.o_frame_err, if_a.o_busy});
    else n_pass++;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    last_a = '0;
    repeat (2 * 16 * BD_A) @(negedge clk);
    n_checks++; if (got_a_n - rd_a !== 0) $display("FAIL midrst_no_partial: got %0d exp 0", got_a_n - rd_a); else n_pass++;
    n_checks++; if (if_a.o_data !== last_a) $display("FAIL midrst_data_cleared: got %h exp %h", if_a.o_data, last_a); else n_pass++;
    align();
    exp_a.push_back(8'h34); last_a = 8'h34;
    send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1, BIT_A);
    repeat (20) @(negedge clk);
    n_checks++; if (got_a_n - rd_a !== exp_a.size()) $display("FAIL midrst_count: got %0d exp %0d", got_a_n - rd_a, exp_a.size()); else n_pass++;
    while (exp_a.size() > 0) begin
      logic [DW-1:0] e;
      e = exp_a.pop_front();
      if (rd_a < got_a_n) begin
        n_checks++; if (got_a_d[rd_a] !== e) $display("FAIL midrst_data: got %h exp %h", got_a_d[rd_a], e); else n_pass++;
        rd_a++;
      end
    end
    n_checks++; if (if_a.o_data !== last_a) $display("FAIL midrst_data_hold: got %h exp %h", if_a.o_data, last_a); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    if_a.i_rx = 1'b1;
    if_p.i_rx = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_random_a();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver and the downstream partner of the team's UART transmitter. It consumes the transmitter's serial line: start bit 0, DATA_W data bits LSB first, optional parity bit, and stop bit 1.
- Oversamples the line 16x from a local prescaler.
- Validates the start bit and samples each bit at mid-bit.
- Delivers parallel words with a one-cycle valid strobe and error flags.

Parameters:
DATA_W, 8, data bits per frame
BAUD_DIV, 27, i_clk cycles per oversample tick (bit period = 16*BAUD_DIV cycles); legal range >=1
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_rx  input  1  serial line, idle high, asynchronous to i_clk
o_data  output  DATA_W  last received word, held until next valid frame
o_valid  output  1  one-cycle pulse: o_data updated
o_parity_err  output  1  one-cycle pulse coincident with o_valid when parity mismatches
o_frame_err  output  1  one-cycle pulse when stop bit sampled 0
o_busy  output  1  high from start-edge detection until return to IDLE

Behaviour:
- Clock and reset:
  - One clock, i_clk.
  - Reset is asynchronous, active-low on i_rst_n.
  - Reset values: o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_busy=0.
  - Reset state: state=IDLE, counters=0, shift register=0, synchronizer flops=1.
- i_rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- Prescaler:
  - Counts 0..BAUD_DIV-1 and asserts tick when at BAUD_DIV-1, then wraps.
  - The prescaler and the 4-bit tick counter are cleared on start-edge detection, so sampling phase is deterministic.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on rx_s falling edge (previous 1, current 0) -> START, o_busy=1.
- START: at the 8th tick after the edge, sample rx_s.
  - If 1: glitch; -> IDLE, o_busy=0, no outputs.
  - If 0: clear tick and bit counters -> DATA.
- DATA:
  - Every 16 ticks, sample rx_s and shift into the MSB of the shift register (LSB-first reception).
  - After DATA_W samples: -> PARITY if PARITY_EN, else -> STOP.
- PARITY:
  - After 16 ticks, sample rx_s.
  - Expected value = XOR of the data bits, XOR PARITY_ODD.
  - Latch the mismatch, then -> STOP.
- STOP: after 16 ticks, sample rx_s.
  - If 1: on the next cycle o_data=shift register, o_valid=1 and o_parity_err=mismatch, both for exactly one cycle. -> IDLE.
  - If 0: on the next cycle o_frame_err=1 for one cycle. No o_valid; o_data unchanged. -> BREAK.
- BREAK: wait until rx_s=1, then -> IDLE. No edge detection occurs in BREAK.
- o_busy drops in the cycle the FSM enters IDLE.
- Latency: o_valid asserts 1 cycle after the mid-stop sample. Sample times counted from edge detection (in ticks):
  - start bit: 8
  - data bit k: 8+16(k+1)
  - stop bit: 8+16(DATA_W+1+PARITY_EN)
- Back-to-back frames:
  - Returning to IDLE at mid-stop lets a start edge half a bit later be caught.
  - An edge arriving in the same cycle as the IDLE entry is detected on the next cycle. The previous-rx_s register updates continuously in every state.
- Mid-frame reset clears everything immediately. No partial word is emitted.
- Line held low at reset release: no falling edge occurs, so nothing is received until the line goes high and then falls.

Test Plan:
1. BAUD_DIV=1, PARITY_EN=0; send 0xA5 with ideal timing -> o_valid high exactly 1 cycle, o_data=0xA5, both error flags 0, o_busy low after the pulse.
2. Pull i_rx low for 4 ticks, then high -> no o_valid and no o_frame_err; FSM in IDLE, o_busy=0 by tick 9.
3. Send 0x3C with stop bit 0, hold the line low 40 ticks, release, then send 0x81 -> o_frame_err pulse only for the first frame; o_data still 0 (or the prior word); then o_valid with o_data=0x81.
4. PARITY_EN=1, PARITY_ODD=0; send 0x07 with parity bit 1 -> o_valid, o_parity_err=0. Send 0x07 with parity bit 0 -> o_valid, o_data=0x07, o_parity_err=1 in the same cycle.
5. Back-to-back frames 0x00, 0xFF, 0x55 with a 1-bit stop and no idle gap, transmitter clock +2% off nominal -> three o_valid pulses with the correct data in order.
6. Assert i_rst_n low during data bit 3 of frame 0x12, release, then send 0x34 -> all outputs 0 during reset, no emission of 0x12, then o_data=0x34 valid.
